// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Command-driven execution controller for an external combinational 8-bit
//   ALU. It holds a small register file and accepts one command at a time
//   over a valid/ready handshake. Each command drives the ALU, writes back
//   the result and updates the Z/C flags. MUL is sequenced as eight
//   shift-add passes through the ALU adder and keeps the low byte of the
//   product.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake
//   cmd_op, cmd_rd, cmd_rs   opcode, destination/operand A, operand B
//   cmd_imm                  immediate (LDI only)
//   alu_a, alu_b, alu_opcode operands and opcode driven to the ALU
//   alu_result, alu_flag_z/c result and flags returned by the ALU
//   done                     one-cycle pulse when a command retires
//   flag_z, flag_c           architectural flags
//   dbg_addr / dbg_data      combinational register-file read port
module alu_sequencer #(
    parameter  int unsigned NREGS = 4,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs,
    input  logic [7:0]    cmd_imm,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [2:0]    alu_opcode,
    input  logic [7:0]    alu_result,
    input  logic          alu_flag_z,
    input  logic          alu_flag_c,
    output logic          done,
    output logic          flag_z,
    output logic          flag_c,
    input  logic [AW-1:0] dbg_addr,
    output logic [7:0]    dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_EOR = 3'b100,
        OP_CMP = 3'b101,
        OP_MUL = 3'b110,
        OP_LDI = 3'b111
    } op_t;

    state_t        state_q, state_d;
    op_t           op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [7:0]    imm_q, imm_d;
    // Operand latches; during MUL a_q doubles as the shifting multiplicand
    // and b_q as the shifting multiplier.
    logic [7:0]    a_q, a_d;
    logic [7:0]    b_q, b_d;
    logic [7:0]    acc_q, acc_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    rf_q [NREGS];
    logic [7:0]    rf_d [NREGS];
    logic          flag_z_q, flag_z_d;
    logic          flag_c_q, flag_c_d;

    logic          accept;
    logic [7:0]    acc_next;

    assign cmd_ready = (state_q == S_IDLE) & ~rst;
    assign accept    = cmd_valid & cmd_ready;
    assign done      = (state_q == S_DONE);
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;
    assign dbg_data  = rf_q[dbg_addr];

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            rd_q     <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (op_t'(cmd_op) == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC:  state_d = S_DONE;
            S_MUL:   if (cnt_q == 3'd7) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ALU drive
    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = 3'b000;
        unique case (state_q)
            S_EXEC: begin
                alu_a = a_q;
                alu_b = b_q;
                unique case (op_q)
                    OP_CMP:  alu_opcode = OP_SUB;
                    OP_LDI:  alu_opcode = 3'b000;
                    default: alu_opcode = op_q;
                endcase
            end
            S_MUL: begin
                alu_a      = acc_q;
                alu_b      = a_q;
                alu_opcode = OP_ADD;
            end
            default: ;
        endcase
    end

    // Operand capture, writeback and flag update
    always_comb begin
        op_d     = op_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        rf_d     = rf_q;
        acc_next = b_q[0] ? alu_result : acc_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = op_t'(cmd_op);
                    rd_d  = cmd_rd;
                    imm_d = cmd_imm;
                    a_d   = rf_q[cmd_rd];
                    b_d   = rf_q[cmd_rs];
                    acc_d = '0;
                    cnt_d = '0;
                end
            end
            S_EXEC: begin
                unique case (op_q)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_EOR: begin
                        rf_d[rd_q] = alu_result;
                        flag_z_d   = alu_flag_z;
                        flag_c_d   = alu_flag_c;
                    end
                    OP_CMP: begin
                        flag_z_d = alu_flag_z;
                        flag_c_d = alu_flag_c;
                    end
                    OP_LDI: begin
                        rf_d[rd_q] = imm_q;
                        flag_z_d   = (imm_q == 8'h00);
                    end
                    default: ;
                endcase
            end
            S_MUL: begin
                acc_d = acc_next;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 3'd1;
                // The last pass writes the updated accumulator directly so the
                // product lands on the same edge as the final add.
                if (cnt_q == 3'd7) begin
                    rf_d[rd_q] = acc_next;
                    flag_z_d   = (acc_next == 8'h00);
                    flag_c_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    localparam int unsigned NREGS = 4;
    localparam int unsigned AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs;
    logic [7:0]    cmd_imm;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [2:0]    alu_opcode;
    logic [7:0]    alu_result;
    logic          alu_flag_z;
    logic          alu_flag_c;
    logic          done;
    logic          flag_z;
    logic          flag_c;
    logic [AW-1:0] dbg_addr;
    logic [7:0]    dbg_data;

    always #10 clk = ~clk;

    alu_sequencer #(.NREGS(NREGS)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs     (cmd_rs),
        .cmd_imm    (cmd_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_flag_z (alu_flag_z),
        .alu_flag_c (alu_flag_c),
        .done       (done),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Combinational 8-bit ALU the sequencer drives.
    always_comb begin
        logic [8:0] s;
        s          = '0;
        alu_flag_c = 1'b0;
        case (alu_opcode)
            3'b000: begin
                s          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_flag_c = s[8];
            end
            3'b001: begin
                s          = {1'b0, alu_a - alu_b};
                alu_flag_c = (alu_a >= alu_b);
            end
            3'b010:  s = {1'b0, alu_a & alu_b};
            3'b011:  s = {1'b0, alu_a | alu_b};
            3'b100:  s = {1'b0, alu_a ^ alu_b};
            default: s = '0;
        endcase
        alu_result = s[7:0];
        alu_flag_z = (s[7:0] == 8'h00);
    end

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [7:0] m_rf [NREGS];
    logic       m_z;
    logic       m_c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_rf[i] = 8'h00;
        m_z = 1'b0;
        m_c = 1'b0;
    endtask

    // Reads every register through the debug port and compares with the model.
    task automatic check_state(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            dbg_addr = AW'(i);
            #1;
            chk($sformatf("%s r%0d", tag, i), dbg_data, m_rf[i]);
        end
        chk({tag, " Z"}, flag_z, m_z);
        chk({tag, " C"}, flag_c, m_c);
    endtask

    task automatic chk_reg(input string tag, input int addr, input logic [7:0] exp);
        dbg_addr = AW'(addr);
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // Issues one command, checks handshake/latency/ALU drive, then updates the
    // model and compares the full architectural state. When chain is set the
    // next command is presented (valid high) straight after the accept edge.
    task automatic run_cmd(input logic [2:0] op, input int rd, input int rs,
                           input logic [7:0] imm, input bit chain,
                           input logic [2:0] nop, input int nrd, input int nrs,
                           input logic [7:0] nimm);
        int         waited;
        int         lat;
        logic [7:0] a, b, r;
        logic [8:0] sum;
        logic       z, c, wr;
        string      nm;
        nm = $sformatf("op%0d r%0d,r%0d", op, rd, rs);
        @(negedge clk);
        chk({nm, " ready at idle"}, cmd_ready, 1'b1);
        chk({nm, " done low at idle"}, done, 1'b0);
        cmd_op    = op;
        cmd_rd    = AW'(rd);
        cmd_rs    = AW'(rs);
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        dbg_addr  = AW'(rd);
        waited    = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) chk({nm, " accept timeout"}, 1'b0, 1'b1);

        a  = m_rf[rd];
        b  = m_rf[rs];
        r  = 8'h00;
        z  = m_z;
        c  = m_c;
        wr = 1'b1;
        case (op)
            3'd0: begin sum = {1'b0, a} + {1'b0, b}; r = sum[7:0]; c = sum[8]; end
            3'd1: begin r = a - b; c = (a >= b); end
            3'd2: begin r = a & b; c = 1'b0; end
            3'd3: begin r = a | b; c = 1'b0; end
            3'd4: begin r = a ^ b; c = 1'b0; end
            3'd5: begin r = a - b; c = (a >= b); wr = 1'b0; end
            3'd6: begin r = 8'((a * b) % 256); c = 1'b0; end
            default: r = imm;
        endcase
        z = (r == 8'h00);

        @(posedge clk);
        #1;
        if (chain) begin
            cmd_op  = nop;
            cmd_rd  = AW'(nrd);
            cmd_rs  = AW'(nrs);
            cmd_imm = nimm;
        end else begin
            cmd_valid = 1'b0;
        end

        lat = (op == 3'd6) ? 9 : 2;
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            chk({nm, " done early"}, done, 1'b0);
            chk({nm, " ready while busy"}, cmd_ready, 1'b0);
            if (k == 1) chk({nm, " dbg before writeback"}, dbg_data, m_rf[rd]);
            if (op == 3'd6) chk({nm, " mul alu_opcode"}, alu_opcode, 3'b000);
            if (k == 1 && op <= 3'd5) begin
                chk({nm, " alu_a"}, alu_a, a);
                chk({nm, " alu_b"}, alu_b, b);
                chk({nm, " alu_opcode"}, alu_opcode, (op == 3'd5) ? 3'b001 : op);
            end
        end
        @(negedge clk);
        chk({nm, " done pulse"}, done, 1'b1);
        chk({nm, " ready during done"}, cmd_ready, 1'b0);
        chk({nm, " alu idle drive"}, {alu_a, alu_b, alu_opcode}, 19'd0);
        if (wr) m_rf[rd] = r;
        m_z = z;
        m_c = c;
        check_state(nm);
    endtask

    task automatic cmd(input logic [2:0] op, input int rd, input int rs, input logic [7:0] imm);
        run_cmd(op, rd, rs, imm, 1'b0, 3'd0, 0, 0, 8'h00);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_rd    = '0;
        cmd_rs    = '0;
        cmd_imm   = '0;
        dbg_addr  = '0;
        model_reset();

        // Reset held two cycles with a command presented
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd7;
        cmd_rd    = '0;
        cmd_imm   = 8'h55;
        repeat (2) begin
            @(negedge clk);
            chk("ready during rst", cmd_ready, 1'b0);
            chk("done during rst", done, 1'b0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready after rst", cmd_ready, 1'b1);
        cmd_valid = 1'b0;
        check_state("post reset");

        // Arithmetic basics
        cmd(3'd7, 0, 0, 8'h05);
        cmd(3'd7, 1, 0, 8'h03);
        cmd(3'd0, 0, 1, 8'h00);
        chk_reg("ADD 5+3", 0, 8'h08);
        chk("ADD 5+3 Z", flag_z, 1'b0);
        chk("ADD 5+3 C", flag_c, 1'b0);
        cmd(3'd1, 1, 0, 8'h00);
        chk_reg("SUB 3-8", 1, 8'hFB);
        chk("SUB 3-8 C", flag_c, 1'b0);

        // Carry/zero from ADD, then AND with itself
        cmd(3'd7, 2, 0, 8'hFF);
        cmd(3'd7, 3, 0, 8'h01);
        cmd(3'd0, 2, 3, 8'h00);
        chk_reg("ADD FF+1", 2, 8'h00);
        chk("ADD FF+1 Z", flag_z, 1'b1);
        chk("ADD FF+1 C", flag_c, 1'b1);
        cmd(3'd2, 3, 3, 8'h00);
        chk_reg("AND r3,r3", 3, 8'h01);
        chk("AND Z", flag_z, 1'b0);
        chk("AND C", flag_c, 1'b0);

        // CMP equal values, EOR with itself
        cmd(3'd7, 1, 0, 8'h05);
        cmd(3'd7, 2, 0, 8'h05);
        cmd(3'd5, 1, 2, 8'h00);
        chk("CMP eq Z", flag_z, 1'b1);
        chk("CMP eq C", flag_c, 1'b1);
        chk_reg("CMP keeps rd", 1, 8'h05);
        cmd(3'd4, 2, 2, 8'h00);
        chk_reg("EOR self", 2, 8'h00);
        chk("EOR self Z", flag_z, 1'b1);

        // Multiply
        cmd(3'd7, 0, 0, 8'h0D);
        cmd(3'd7, 1, 0, 8'h0B);
        cmd(3'd6, 0, 1, 8'h00);
        chk_reg("MUL D*B", 0, 8'h8F);
        cmd(3'd7, 2, 0, 8'h10);
        cmd(3'd7, 3, 0, 8'h10);
        cmd(3'd6, 2, 3, 8'h00);
        chk_reg("MUL 10*10", 2, 8'h00);
        chk("MUL 10*10 Z", flag_z, 1'b1);
        chk("MUL 10*10 C", flag_c, 1'b0);
        cmd(3'd7, 1, 0, 8'h03);
        cmd(3'd6, 1, 1, 8'h00);
        chk_reg("MUL 3*3", 1, 8'h09);

        // Back-to-back: second command held valid while the first is busy
        run_cmd(3'd7, 0, 0, 8'h21, 1'b1, 3'd0, 0, 0, 8'h00);
        run_cmd(3'd0, 0, 0, 8'h00, 1'b0, 3'd0, 0, 0, 8'h00);
        chk_reg("chained ADD", 0, 8'h42);
        run_cmd(3'd7, 3, 0, 8'h07, 1'b1, 3'd6, 3, 1, 8'h00);
        run_cmd(3'd6, 3, 1, 8'h00, 1'b0, 3'd0, 0, 0, 8'h00);

        // Reset in MUL cycle 4 aborts the command
        @(negedge clk);
        cmd_op    = 3'd6;
        cmd_rd    = '0;
        cmd_rs    = 2'd1;
        cmd_valid = 1'b1;
        chk("abort mul ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("idle after abort", cmd_ready, 1'b1);
        check_state("after abort");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("no done after abort", done, 1'b0);
        end

        // Randomised commands
        for (int n = 0; n < 60; n++) begin
            cmd(3'($urandom_range(0, 7)), int'($urandom_range(0, NREGS - 1)),
                int'($urandom_range(0, NREGS - 1)), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven execution controller for the 8-bit ALU. It holds a small register file and accepts one command at a time over a valid/ready handshake. For each command it drives the ALU with the operands, writes back the result and updates the Z/C flags. It also sequences a multi-cycle 8×8 multiply (low byte) as eight shift-add passes through the ALU adder. It sits between the command source (decoder/testbench) and the combinational ALU instance.

## Interface
- NREGS, 4, number of 8-bit registers (power of 2, ≥2); AW = $clog2(NREGS)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 EOR, 101 CMP, 110 MUL, 111 LDI
- cmd_rd  in  AW  destination register and first operand A
- cmd_rs  in  AW  second operand register B
- cmd_imm  in  8  immediate, used by LDI only
- alu_a, alu_b  out  8  ALU operands
- alu_opcode  out  3  ALU opcode
- alu_result  in  8  ALU result
- alu_flag_z, alu_flag_c  in  1  ALU flags (C = adder carry-out; SUB carry = no borrow)
- done  out  1  one-cycle pulse: command retired
- flag_z, flag_c  out  1  architectural flags
- dbg_addr  in  AW  debug register read address
- dbg_data  out  8  combinational read of rf[dbg_addr]

## Operation
- States: IDLE, EXEC, MUL, DONE. Transitions:
  - IDLE→EXEC on accept of ops 000–101 or 111.
  - IDLE→MUL on accept of 110.
  - EXEC→DONE.
  - MUL→DONE after 8th iteration.
  - DONE→IDLE.
- cmd_ready = (state==IDLE) & ~rst. Accept = cmd_valid & cmd_ready.
- On accept, latch op, rd, imm, A=rf[cmd_rd] and B=rf[cmd_rs]. rd==rs is legal; both operands get the same value.
- EXEC drives alu_a=A, alu_b=B and alu_opcode:
  - ADD/SUB/AND/OR/EOR: opcode=cmd_op. rf[rd]←alu_result, flag_z←alu_flag_z, flag_c←alu_flag_c.
  - CMP: opcode=001. Flags are updated; rf is unchanged.
  - LDI: ALU not used. rf[rd]←imm, flag_z←(imm==0), flag_c unchanged.
- MUL setup:
  - acc=0, mcand=A, mplier=B, iteration count 0..7.
  - Each MUL cycle drives alu_a=acc, alu_b=mcand, alu_opcode=000.
- MUL per cycle:
  - If mplier[0], acc←alu_result.
  - mcand←mcand<<1, mplier←mplier>>1.
- MUL final cycle: rf[rd]←final acc (product mod 256), flag_z←(product==0), flag_c←0.
- Outside EXEC/MUL: alu_a=alu_b=0, alu_opcode=000.
- cmd_* are ignored unless accepted. A command held valid while busy is accepted on the first IDLE cycle.
- Reset:
  - All rf entries 0; flag_z=flag_c=0; done=0; state=IDLE.
  - Reset mid-command aborts it: no writeback, no done.
- dbg_data shows the old value until the writeback edge.

## Timing
- Accept edge at end of cycle t.
- Non-MUL commands:
  - EXEC in cycle t+1; rf and flags update at the end of t+1.
  - done=1 in t+2 (DONE); cmd_ready=1 again in t+3.
  - Throughput: one command per 3 cycles.
- MUL:
  - MUL state in cycles t+1..t+8; writeback at the end of t+8.
  - done=1 in t+9; cmd_ready=1 in t+10.
- done is high for exactly one cycle per retired command, and never in the same cycle as cmd_ready.
- ALU is purely combinational; its result is consumed in the same cycle its inputs are driven.

## Test plan
- Reset: hold rst 2 cycles with cmd_valid=1 → cmd_ready=0 during rst; afterwards all dbg reads 0x00, flags 0, no accept during rst, cmd_ready=1 on the first post-reset cycle.
- LDI r0=0x05, LDI r1=0x03, ADD rd=0 rs=1 → r0=0x08, Z=0, C=0, done exactly 2 cycles after accept. Then SUB rd=1 rs=0 (0x03−0x08) → r1=0xFB, C=0.
- LDI r2=0xFF, LDI r3=0x01, ADD rd=2 rs=3 → r2=0x00, Z=1, C=1. Then AND rd=3 rs=3 → r3=0x01, Z=0, C=0.
- CMP with both registers 0x05 → Z=1, C=1, register unchanged. EOR rd=rs → rd=0x00, Z=1.
- MUL r0=0x0D, r1=0x0B → r0=0x8F, done 9 cycles after accept, alu_opcode=000 for all 8 MUL cycles. MUL 0x10×0x10 → 0x00, Z=1, C=0. MUL with rd==rs=0x03 → 0x09.
- Back-to-back: cmd_valid held high with two queued commands → second accepted exactly one cycle after the first's done. rst asserted in MUL cycle 4 → no done, all regs 0, IDLE next cycle.
